seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Scan controller for a 4-digit multiplexed, common-anode seven-segment display. It contains its own prescaler tick (one strobe every DIV clocks) and steps the digit scan on each tick. Digit values arrive through a load port into shadow registers. A commit request copies the shadow registers to the displayed set only at a scan-frame boundary, so the display never tears mid-frame. It sits between the counter/loader logic and the board's anode and segment pins.

## Interface
- DIV, 5000, clk cycles per scan tick; legal range ≥ 2; prescaler width is $clog2(DIV).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- load  in  1  write load_val into shadow digit load_addr on this edge.
- load_addr  in  2  shadow digit index; 0 = least significant, 3 = most significant.
- load_val  in  4  hex digit value 0x0–0xF.
- commit  in  1  request copy of shadow → active at next frame boundary.
- lz_en  in  1  leading-zero suppression enable; sampled at each tick.
- pending  out  1  commit requested and not yet performed.
- commit_done  out  1  one-cycle pulse on the cycle after the copy edge.
- an  out  4  anode enables, active-low, one-hot-low while scanning.
- seg  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}.

## Operation
- Prescaler: cnt counts 0..DIV-1 and wraps to 0. tick = (cnt == DIV-1), combinational and internal.
- Scan index idx (2 bits): on each tick edge, an/seg load the decode of digit idx, then idx ← idx+1 mod 4.
- an for digit k drives bit k low and all other bits high.
- Frame boundary: a tick edge with idx == 3.
- Shadow regs sh[0..3] (4 bits each): written by load on the edge. Loads are accepted every cycle; no backpressure.
- Active regs act[0..3]: written only at a frame boundary while pending = 1. All four digits take the pre-edge shadow values.
- commit: sets pending on the edge. commit while pending = 1 has no additional effect.
- Frame-boundary copy: clears pending. commit_done = 1 for exactly the following cycle.
- Simultaneous events:
  - load and copy on the same edge: the copy uses the old shadow value; the new value stays in shadow only.
  - commit and copy on the same edge: the copy occurs, and pending stays 1 (the new request is served at the next frame).
- Decode, hex, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero suppression: digit k (k ≥ 1) is blanked when lz_en = 1 and act[3..k] are all 0.
  - Blanked means seg = 1111111; the anode is still driven.
  - Digit 0 is never blanked.

## Timing
- Reset values (asynchronous assert, all immediate):
  - cnt=0, idx=0, sh=0, act=0, pending=0, commit_done=0
  - an=4'b1111, seg=7'b1111111
- After reset release, the first tick edge is the DIV-th rising edge. an/seg then show digit 0.
- an/seg are registered. They change only on tick edges and are stable for DIV cycles.
- Full frame = 4·DIV cycles. The digit sequence is 0,1,2,3,0,…
- Commit latency:
  - Commit to copy takes from 1 edge to 4·DIV edges, depending on scan position.
  - The new values first appear on the tick after the copy, which shows digit 0.
- pending is registered: it rises the edge after commit and falls on the copy edge.
- Reset mid-frame discards pending requests and all loaded data. There is no partial copy.

## Test plan
- Reset then idle, DIV=4:
  - an=1111 and seg=1111111 for the first 3 edges.
  - At edge 4: an=1110, seg=1000000.
  - After that: an = 1101, 1011, 0111, 1110 every 4 cycles.
- Load digits 3..0 with 1,2,3,4, then commit mid-frame:
  - pending=1 until the idx==3 tick.
  - commit_done pulses once.
  - The next four ticks show seg 0011001, 0110000, 0100100, 1111001.
- Load without commit: load sh[0]=8. Display stays at the previous active values for ≥ 3 frames; pending=0.
- Simultaneous load+copy: commit pending, and on the copy edge load sh[2]=F.
  - The copied act[2] is the old value.
  - A second commit then shows F (0001110) on digit 2.
- Leading zeros: act = 0,0,7,0 (digits 3..0) with lz_en=1.
  - Digits 3 and 2 show 1111111.
  - Digit 1 shows 1111000.
  - Digit 0 shows 1000000.
- Reset asserted mid-frame with pending=1: an/seg blank at once; pending=0; act=0. No commit_done appears after release.

Source files
------------

// File: rtl/seg_scan_if.sv
// Load/commit/display bundle between the digit loader and the seven-segment scan controller.
// The master side drives digit loads and commit requests; the slave side returns status and pins.
interface seg_scan_if;
   logic       load;
   logic [1:0] load_addr;
   logic [3:0] load_val;
   logic       commit;
   logic       lz_en;
   logic       pending;
   logic       commit_done;
   logic [3:0] an;
   logic [6:0] seg;

   modport master (
      output load, load_addr, load_val, commit, lz_en,
      input  pending, commit_done, an, seg
   );

   modport slave (
      input  load, load_addr, load_val, commit, lz_en,
      output pending, commit_done, an, seg
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode seven-segment scan controller with shadow/active digit
// banks; a commit copies shadow to active only at a scan-frame boundary.
module seg_scan_ctrl #(
   parameter int DIV = 5000
) (
   input  logic      clk,
   input  logic      reset,
   seg_scan_if.slave bus
);

   localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   typedef enum logic {
      ST_IDLE,
      ST_PENDING
   } commit_state_t;

   logic [CW-1:0] cnt;
   logic          tick;
   logic [1:0]    idx;
   logic          frame_edge;

   logic [3:0]    sh  [4];
   logic [3:0]    act [4];

   commit_state_t state;
   commit_state_t state_nxt;
   logic          copy;
   logic          done_q;

   logic [3:0]    upper_zero;
   logic          blank;
   logic [3:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic [3:0]    an_q;
   logic [6:0]    seg_q;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Prescaler and scan index
   assign tick       = (cnt == CNT_MAX);
   assign frame_edge = tick && (idx == 2'd3);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (tick) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Commit request tracker: a commit arriving on the copy edge is kept for the next frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      copy      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.commit) state_nxt = ST_PENDING;
         end
         ST_PENDING: begin
            if (frame_edge) begin
               copy      = 1'b1;
               state_nxt = bus.commit ? ST_PENDING : ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: the small digit banks are reset explicitly, since a reset must discard all loaded data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            sh[i]  <= 4'h0;
            act[i] <= 4'h0;
         end
         done_q <= 1'b0;
      end else begin
         if (bus.load) sh[bus.load_addr] <= bus.load_val;
         if (copy) begin
            for (int i = 0; i < 4; i++) act[i] <= sh[i];
         end
         done_q <= copy;
      end
   end

   // Leading-zero blanking: digit k is blank when all active digits k..3 are zero.
   always_comb begin
      upper_zero    = 4'b0000;
      upper_zero[3] = (act[3] == 4'h0);
      upper_zero[2] = upper_zero[3] && (act[2] == 4'h0);
      upper_zero[1] = upper_zero[2] && (act[1] == 4'h0);
      upper_zero[0] = upper_zero[1] && (act[0] == 4'h0);
      blank         = bus.lz_en && (idx != 2'd0) && upper_zero[idx];
      an_nxt        = ~(4'b0001 << idx);
      seg_nxt       = blank ? 7'b1111111 : hex7(act[idx]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_q  <= 4'b1111;
         seg_q <= 7'b1111111;
      end else if (tick) begin
         an_q  <= an_nxt;
         seg_q <= seg_nxt;
      end
   end

   assign bus.an          = an_q;
   assign bus.seg         = seg_q;
   assign bus.pending     = (state == ST_PENDING);
   assign bus.commit_done = done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, checked against
// an edge-count based model of the display, shadow/active banks and commit requests.
module tb_seg_scan_ctrl;

   localparam int DIV = 4;

   logic clk;
   logic reset;
   seg_scan_if bus ();

   seg_scan_ctrl #(.DIV(DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [6:0] dec_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Model state: edges since reset release and the banks as the spec describes them
   int         n;
   logic [3:0] sh_m  [4];
   logic [3:0] act_m [4];
   logic       pend_m;
   logic       done_m;
   logic [3:0] an_m;
   logic [6:0] seg_m;
   logic       last_tick;
   int         last_d;
   logic [6:0] seen_seg [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] exp_disp(input int d, input logic lz);
      logic all_zero;
      all_zero = 1'b1;
      for (int j = d; j < 4; j++) if (act_m[j] != 4'h0) all_zero = 1'b0;
      if (lz && d >= 1 && all_zero) return 7'b1111111;
      return dec_tab[act_m[d]];
   endfunction

   task automatic model_reset();
      n      = 0;
      pend_m = 1'b0;
      done_m = 1'b0;
      an_m   = 4'b1111;
      seg_m  = 7'b1111111;
      last_tick = 1'b0;
      last_d    = 0;
      for (int i = 0; i < 4; i++) begin
         sh_m[i]  = 4'h0;
         act_m[i] = 4'h0;
      end
   endtask

   function automatic logic next_is_copy();
      return ((n % DIV) == DIV - 1) && (((n / DIV) % 4) == 3) && pend_m;
   endfunction

   // Apply one clock edge to the model using the inputs currently on the bus
   task automatic model_edge();
      logic tk;
      logic cp;
      int   d;
      tk = ((n % DIV) == DIV - 1);
      d  = (n / DIV) % 4;
      cp = tk && (d == 3) && pend_m;
      last_tick = tk;
      last_d    = d;
      if (tk) begin
         an_m      = 4'b1111;
         an_m[d]   = 1'b0;
         seg_m     = exp_disp(d, bus.lz_en);
      end
      done_m = cp;
      if (cp) begin
         for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
         pend_m = bus.commit;
      end else begin
         pend_m = pend_m | bus.commit;
      end
      if (bus.load) sh_m[bus.load_addr] = bus.load_val;
      n++;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".an"},          32'(bus.an),          32'(an_m));
      check({tag, ".seg"},         32'(bus.seg),         32'(seg_m));
      check({tag, ".pending"},     32'(bus.pending),     32'(pend_m));
      check({tag, ".commit_done"}, 32'(bus.commit_done), 32'(done_m));
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      compare_all(tag);
      if (last_tick) seen_seg[last_d] = bus.seg;
      bus.load   = 1'b0;
      bus.commit = 1'b0;
   endtask

   task automatic run(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) cycle(tag);
   endtask

   task automatic load_digit(input logic [1:0] a, input logic [3:0] v);
      bus.load      = 1'b1;
      bus.load_addr = a;
      bus.load_val  = v;
      cycle("load");
   endtask

   // Assert reset between edges, hold it over a few edges, then release
   task automatic apply_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check("rst.an",      32'(bus.an),          32'h0F);
      check("rst.seg",     32'(bus.seg),         32'h7F);
      check("rst.pending", 32'(bus.pending),     32'h0);
      check("rst.done",    32'(bus.commit_done), 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         compare_all("rst_hold");
      end
      reset = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      bus.load      = 1'b0;
      bus.load_addr = 2'd0;
      bus.load_val  = 4'h0;
      bus.commit    = 1'b0;
      bus.lz_en     = 1'b0;
      #2;
      apply_reset();

      // Reset then idle: blank for DIV-1 edges, digit 0 on the DIV-th edge
      for (int i = 0; i < DIV - 1; i++) begin
         cycle("idle");
         check("idle.an_blank", 32'(bus.an), 32'h0F);
      end
      cycle("idle");
      check("first_tick.an",  32'(bus.an),  32'(4'b1110));
      check("first_tick.seg", 32'(bus.seg), 32'(7'b1000000));
      run("idle_scan", 4 * DIV * 2);

      // Load 1,2,3,4 into digits 3..0 and commit mid-frame
      load_digit(2'd3, 4'h1);
      load_digit(2'd2, 4'h2);
      load_digit(2'd1, 4'h3);
      load_digit(2'd0, 4'h4);
      bus.commit = 1'b1;
      cycle("commit1");
      check("commit1.pending", 32'(bus.pending), 32'h1);
      run("commit1_wait", 4 * DIV * 3);
      check("digits.d0", 32'(seen_seg[0]), 32'(7'b0011001));
      check("digits.d1", 32'(seen_seg[1]), 32'(7'b0110000));
      check("digits.d2", 32'(seen_seg[2]), 32'(7'b0100100));
      check("digits.d3", 32'(seen_seg[3]), 32'(7'b1111001));

      // Load without commit leaves the display alone
      load_digit(2'd0, 4'h8);
      run("no_commit", 4 * DIV * 3);
      check("no_commit.d0", 32'(seen_seg[0]), 32'(7'b0011001));
      check("no_commit.pending", 32'(bus.pending), 32'h0);

      // Load on the copy edge: copy takes the old shadow value
      bus.commit = 1'b1;
      cycle("commit2");
      begin
         int budget;
         budget = 4 * DIV + 2;
         while (!next_is_copy() && budget > 0) begin
            cycle("find_copy");
            budget--;
         end
         check("find_copy.in_budget", 32'(budget > 0), 32'h1);
      end
      bus.load      = 1'b1;
      bus.load_addr = 2'd2;
      bus.load_val  = 4'hF;
      cycle("load_on_copy");
      run("after_copy", 4 * DIV * 2);
      check("load_copy.d2_old", 32'(seen_seg[2]), 32'(7'b0100100));
      check("load_copy.d0_new", 32'(seen_seg[0]), 32'(7'b0000000));
      bus.commit = 1'b1;
      cycle("commit3");
      run("commit3_wait", 4 * DIV * 3);
      check("second_commit.d2", 32'(seen_seg[2]), 32'(7'b0001110));

      // Leading-zero suppression on 0,0,7,0
      load_digit(2'd3, 4'h0);
      load_digit(2'd2, 4'h0);
      load_digit(2'd1, 4'h7);
      load_digit(2'd0, 4'h0);
      bus.lz_en  = 1'b1;
      bus.commit = 1'b1;
      cycle("commit_lz");
      run("lz_wait", 4 * DIV * 3);
      check("lz.d3", 32'(seen_seg[3]), 32'(7'b1111111));
      check("lz.d2", 32'(seen_seg[2]), 32'(7'b1111111));
      check("lz.d1", 32'(seen_seg[1]), 32'(7'b1111000));
      check("lz.d0", 32'(seen_seg[0]), 32'(7'b1000000));

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         bus.load      = ($urandom_range(0, 2) == 0);
         bus.load_addr = 2'($urandom_range(0, 3));
         bus.load_val  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         bus.commit    = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 15) == 0) bus.lz_en = ~bus.lz_en;
         cycle("random");
      end

      // Reset mid-frame with a pending commit
      load_digit(2'd0, 4'h5);
      bus.commit = 1'b1;
      cycle("commit_pre_reset");
      cycle("pre_reset");
      check("pre_reset.pending", 32'(bus.pending), 32'h1);
      bus.lz_en = 1'b0;
      apply_reset();
      run("post_reset", 4 * DIV * 3);
      check("post_reset.d0", 32'(seen_seg[0]), 32'(7'b1000000));
      check("post_reset.d3", 32'(seen_seg[3]), 32'(7'b1000000));
      check("post_reset.pending", 32'(bus.pending), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
